// File: rtl/ssi_encoder_reader.sv
// SSI absolute encoder reader: clocks out one DATA_BITS frame MSB first,
// waits out the encoder monoflop, then publishes the position or an error.
// Optional feature: define SSI_GRAY_DECODE_EN to Gray-to-binary convert the
// captured frame before it is loaded into location_detection_value_out.
module ssi_encoder_reader #(
    parameter int unsigned DATA_BITS       = 13,
    parameter int unsigned CLK_DIV         = 100,
    parameter int unsigned MONOFLOP_CYCLES = 2000
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 location_detection_enable_in,
    input  logic                 vlx_data_in,
    output logic                 vlx_clk_out,
    output logic [DATA_BITS-1:0] location_detection_value_out,
    output logic                 position_valid_out,
    output logic                 frame_error_out,
    output logic                 busy_out
);

    // Each counter holds 0..terminal, so it needs $clog2(terminal + 1) bits.
    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned MONO_W = (MONOFLOP_CYCLES > 1) ? $clog2(MONOFLOP_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [MONO_W-1:0] MONO_LAST = MONO_W'(MONOFLOP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MONOFLOP,
        ST_UPDATE,
        ST_ERROR
    } state_t;

    state_t               state;
    logic                 data_sync1;
    logic                 data_sync2;
    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     div_next_c;
    logic [BIT_W-1:0]     bit_cnt;
    logic [MONO_W-1:0]    mono_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] frame_data_c;

    // Two-flop synchronizer for the encoder data line.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            data_sync1 <= 1'b0;
            data_sync2 <= 1'b0;
        end else begin
            data_sync1 <= vlx_data_in;
            data_sync2 <= data_sync1;
        end
    end

    // Period counter successor; wraps at the end of each SSI clock period.
    always_comb begin
        div_next_c = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

`ifdef SSI_GRAY_DECODE_EN
    // Gray-to-binary conversion of the captured frame, MSB downwards.
    always_comb begin
        frame_data_c                = '0;
        frame_data_c[DATA_BITS-1]   = shift_reg[DATA_BITS-1];
        for (int i = DATA_BITS - 2; i >= 0; i--) begin
            frame_data_c[i] = frame_data_c[i+1] ^ shift_reg[i];
        end
    end
`else
    // Raw captured frame is the published value.
    always_comb begin
        frame_data_c = shift_reg;
    end
`endif

    // Frame sequencer: drives the SSI clock, captures bits and publishes results.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state                        <= ST_IDLE;
            div_cnt                      <= '0;
            bit_cnt                      <= '0;
            mono_cnt                     <= '0;
            shift_reg                    <= '0;
            vlx_clk_out                  <= 1'b1;
            location_detection_value_out <= '0;
            position_valid_out           <= 1'b0;
            frame_error_out              <= 1'b0;
            busy_out                     <= 1'b0;
        end else begin
            position_valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    div_cnt     <= '0;
                    bit_cnt     <= '0;
                    mono_cnt    <= '0;
                    vlx_clk_out <= 1'b1;
                    if (location_detection_enable_in) begin
                        busy_out <= 1'b1;
                        // A low line before any clock means the encoder is not ready.
                        if (data_sync2) begin
                            state       <= ST_SHIFT;
                            vlx_clk_out <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end
                end
                ST_SHIFT: begin
                    div_cnt     <= div_next_c;
                    vlx_clk_out <= (div_next_c >= DIV_HALF);
                    if (div_cnt == DIV_LAST) begin
                        shift_reg <= {shift_reg[DATA_BITS-2:0], data_sync2};
                        if (bit_cnt == BIT_LAST) begin
                            state       <= ST_MONOFLOP;
                            vlx_clk_out <= 1'b1;
                            bit_cnt     <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_MONOFLOP: begin
                    vlx_clk_out <= 1'b1;
                    if (mono_cnt == MONO_LAST) begin
                        mono_cnt <= '0;
                        // Encoder must have released the line once its monoflop expired.
                        state    <= data_sync2 ? ST_UPDATE : ST_ERROR;
                    end else begin
                        mono_cnt <= mono_cnt + MONO_W'(1);
                    end
                end
                ST_UPDATE: begin
                    location_detection_value_out <= frame_data_c;
                    frame_error_out              <= 1'b0;
                    position_valid_out           <= 1'b1;
                    busy_out                     <= 1'b0;
                    state                        <= ST_IDLE;
                end
                ST_ERROR: begin
                    frame_error_out    <= 1'b1;
                    position_valid_out <= 1'b1;
                    busy_out           <= 1'b0;
                    state              <= ST_IDLE;
                end
                default: begin
                    vlx_clk_out <= 1'b1;
                    busy_out    <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssi_encoder_reader.sv
// Bench for ssi_encoder_reader with a behavioural SSI encoder and a scoreboard
// of expected frame results checked at every position_valid_out pulse.
module tb_ssi_encoder_reader;

    localparam int DATA_BITS = 13;
    localparam int CLK_DIV   = 8;
    localparam int MONO      = 40;
    localparam int FRAME_LAT = 2 + DATA_BITS * CLK_DIV + MONO;
    localparam int NV        = 7;

    logic                 sys_clk = 1'b0;
    logic                 reset;
    logic                 req;
    logic                 vlx_data_in;
    logic                 vlx_clk_out;
    logic [DATA_BITS-1:0] value;
    logic                 valid;
    logic                 ferr;
    logic                 busy;

    logic                 enc_line    = 1'b1;
    logic                 pre_low     = 1'b0;
    logic                 mono_low    = 1'b0;
    logic                 model_abort = 1'b0;
    logic [DATA_BITS-1:0] cur_frame   = '0;

    assign vlx_data_in = pre_low ? 1'b0 : enc_line;

    ssi_encoder_reader #(
        .DATA_BITS(DATA_BITS),
        .CLK_DIV(CLK_DIV),
        .MONOFLOP_CYCLES(MONO)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .location_detection_enable_in(req),
        .vlx_data_in(vlx_data_in),
        .vlx_clk_out(vlx_clk_out),
        .location_detection_value_out(value),
        .position_valid_out(valid),
        .frame_error_out(ferr),
        .busy_out(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_BITS-1:0] frame;
        bit                   pre_low;
        bit                   mono_low;
        logic [DATA_BITS-1:0] exp_val;
        bit                   exp_err;
        int                   exp_lat;
        int                   exp_falls;
    } vec_t;

    typedef struct {
        logic [DATA_BITS-1:0] val;
        bit                   err;
        int                   lat;
        int                   falls;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[NV];

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   falls = 0;
    int   low_cycles = 0;
    int   busy_low = 0;
    int   frame_start = 0;
    logic clk_prev = 1'b1;

    // Encoder model: MSB first, a new bit after each rising clock, then the
    // monoflop low time, then the line released (or held low on request).
    initial begin : enc_model
        bit aborted;
        forever begin
            @(negedge vlx_clk_out);
            aborted = 1'b0;
            for (int k = 0; k < DATA_BITS && !aborted; k++) begin
                @(posedge vlx_clk_out or posedge model_abort);
                if (model_abort) begin
                    aborted = 1'b1;
                end else begin
                    #1;
                    enc_line = cur_frame[DATA_BITS-1-k];
                end
            end
            if (!aborted) begin
                repeat (CLK_DIV) @(posedge sys_clk);
                #1 enc_line = 1'b0;
                repeat (20) @(posedge sys_clk);
                #1 enc_line = !mono_low;
                @(posedge valid or posedge model_abort);
            end
            enc_line = 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_BITS-1:0] decode(input logic [DATA_BITS-1:0] g);
`ifdef SSI_GRAY_DECODE_EN
        logic [DATA_BITS-1:0] b;
        for (int i = 0; i < DATA_BITS; i++) b[i] = ^(g >> i);
        return b;
`else
        return g;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: sample at the falling edge, score any valid pulse.
    task automatic tick();
        exp_t e;
        @(negedge sys_clk);
        if (!vlx_clk_out) low_cycles++;
        if (clk_prev && !vlx_clk_out) falls++;
        clk_prev = vlx_clk_out;
        if (!busy) busy_low++;
        if (valid) begin
            n_valid++;
            check("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("value", 32'(value), 32'(e.val));
                check("frame_error", 32'(ferr), 32'(e.err));
                check("latency", 32'(cyc - frame_start), 32'(e.lat));
                check("clk_falls", 32'(falls), 32'(e.falls));
                check("clk_low_cycles", 32'(low_cycles), 32'(e.falls * CLK_DIV / 2));
                check("busy_at_valid", 32'(busy), 32'd0);
            end
            if (req) begin
                frame_start = cyc;
                falls       = 0;
                low_cycles  = 0;
            end
        end
    endtask

    task automatic start_frame();
        req         = 1'b1;
        frame_start = cyc;
        falls       = 0;
        low_cycles  = 0;
        clk_prev    = vlx_clk_out;
    endtask

    task automatic pulse_request();
        start_frame();
        tick();
        req = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int start_n;
        int k;
        start_n = n_valid;
        k = 0;
        while (n_valid == start_n && k < budget) begin
            tick();
            k++;
        end
        check("valid_in_time", 32'(n_valid != start_n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vlx_clk"}, 32'(vlx_clk_out), 32'd1);
        check({tag, "_value"}, 32'(value), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_error"}, 32'(ferr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin : main
        logic [DATA_BITS-1:0] last;
        exp_t e;
        int   k;
        int   nv0;

        reset = 1'b1;
        req   = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) tick();

        tbl[0] = '{13'h0A5C, 1'b0, 1'b0, '0, 1'b0, 0, 0};
        tbl[1] = '{13'h0A5C, 1'b1, 1'b0, '0, 1'b0, 0, 0};
        tbl[2] = '{13'h1234, 1'b0, 1'b1, '0, 1'b0, 0, 0};
        tbl[3] = '{13'h1000, 1'b0, 1'b0, '0, 1'b0, 0, 0};
        tbl[4] = '{13'h1FFF, 1'b0, 1'b0, '0, 1'b0, 0, 0};
        tbl[5] = '{13'h0001, 1'b0, 1'b0, '0, 1'b0, 0, 0};
        tbl[6] = '{13'h0000, 1'b0, 1'b0, '0, 1'b0, 0, 0};
        last = '0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].pre_low || tbl[i].mono_low) begin
                tbl[i].exp_val = last;
                tbl[i].exp_err = 1'b1;
            end else begin
                last           = decode(tbl[i].frame);
                tbl[i].exp_val = last;
                tbl[i].exp_err = 1'b0;
            end
            tbl[i].exp_lat   = tbl[i].pre_low ? 2 : FRAME_LAT;
            tbl[i].exp_falls = tbl[i].pre_low ? 0 : DATA_BITS;
        end

        for (int i = 0; i < NV; i++) begin
            pre_low   = tbl[i].pre_low;
            mono_low  = tbl[i].mono_low;
            cur_frame = tbl[i].frame;
            repeat (4) tick();
            e = '{tbl[i].exp_val, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_falls};
            sb.push_back(e);
            pulse_request();
            wait_valid(FRAME_LAT + 20);
            pre_low  = 1'b0;
            mono_low = 1'b0;
            repeat (4) tick();
            check("error_held", 32'(ferr), 32'(tbl[i].exp_err));
            check("value_held", 32'(value), 32'(tbl[i].exp_val));
        end

        // Reset during bit 6 aborts the frame with no valid pulse.
        cur_frame = 13'h0F0F;
        repeat (2) tick();
        pulse_request();
        k = 0;
        while (falls < 7 && k < 200) begin
            tick();
            k++;
        end
        check("reach_bit6", 32'(falls), 32'd7);
        reset       = 1'b1;
        model_abort = 1'b1;
        sb.delete();
        tick();
        check_reset_outputs("abort");
        reset = 1'b0;
        repeat (2) tick();
        model_abort = 1'b0;
        nv0 = n_valid;
        repeat (FRAME_LAT) tick();
        check("no_valid_after_abort", 32'(n_valid), 32'(nv0));

        cur_frame = 13'h1555;
        e = '{decode(13'h1555), 1'b0, FRAME_LAT, DATA_BITS};
        sb.push_back(e);
        pulse_request();
        wait_valid(FRAME_LAT + 20);
        repeat (4) tick();

        // Request held high: three back-to-back frames, one idle cycle between.
        cur_frame = 13'h1234;
        e = '{decode(13'h1234), 1'b0, FRAME_LAT, DATA_BITS};
        repeat (3) sb.push_back(e);
        start_frame();
        tick();
        busy_low = 0;
        nv0      = n_valid;
        k        = 0;
        while (n_valid < nv0 + 3 && k < 3 * FRAME_LAT + 50) begin
            tick();
            k++;
        end
        req = 1'b0;
        check("b2b_valid_count", 32'(n_valid - nv0), 32'd3);
        check("b2b_busy_low_cycles", 32'(busy_low), 32'd3);
        repeat (20) tick();
        check("b2b_stopped_busy", 32'(busy), 32'd0);
        check("b2b_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ssi_encoder_reader.md
SSI_ENCODER_READER -- requirements
Module: ssi_encoder_reader

Interface
REQ-001 SHALL have parameter DATA_BITS, default 13, meaning encoder frame width in bits (range 2..32).
REQ-002 SHALL have parameter CLK_DIV, default 100, meaning sys_clk cycles per SSI clock period (even, >=4).
REQ-003 SHALL have parameter MONOFLOP_CYCLES, default 2000, meaning sys_clk cycles of encoder monoflop wait after the last bit (>=1).
REQ-004 SHALL have ports: sys_clk  in  1  system clock.
REQ-005 reset  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 location_detection_enable_in  in  1  read request, level-sampled, accepted only in IDLE.
REQ-007 vlx_data_in  in  1  SSI data from encoder, asynchronous to sys_clk.
REQ-008 vlx_clk_out  out  1  SSI clock to encoder, idle high.
REQ-009 location_detection_value_out  out  DATA_BITS  last good position.
REQ-010 position_valid_out  out  1  one-cycle pulse, frame finished (good or bad).
REQ-011 frame_error_out  out  1  status of last frame, held until next valid pulse.
REQ-012 busy_out  out  1  high in every state except IDLE.

Function
REQ-013 vlx_data_in SHALL pass a 2-flop synchronizer; all sampling uses the second stage.
REQ-014 States SHALL be IDLE, SHIFT, MONOFLOP, UPDATE, ERROR.
REQ-015 IDLE with request and synced data high -> SHIFT; with synced data low -> ERROR (no clocks issued).
REQ-016 SHIFT SHALL last exactly DATA_BITS*CLK_DIV cycles; period counter 0..CLK_DIV-1; vlx_clk_out low for counts 0..CLK_DIV/2-1, high otherwise.
REQ-017 Data SHALL be sampled at count CLK_DIV-1 of each period, shifted in MSB first into a DATA_BITS shift register.
REQ-018 After the last bit sample, SHIFT -> MONOFLOP; vlx_clk_out held high throughout MONOFLOP, UPDATE, ERROR, IDLE.
REQ-019 MONOFLOP SHALL last exactly MONOFLOP_CYCLES cycles, then -> UPDATE if synced data high, else -> ERROR.
REQ-020 UPDATE (1 cycle) SHALL load location_detection_value_out, clear frame_error_out, pulse position_valid_out on the following cycle; -> IDLE.
REQ-021 ERROR (1 cycle) SHALL keep location_detection_value_out unchanged, set frame_error_out, pulse position_valid_out on the following cycle; -> IDLE.
REQ-022 Latency, request sampled to valid pulse, good frame: 2 + DATA_BITS*CLK_DIV + MONOFLOP_CYCLES cycles; precheck error: 2 cycles.
REQ-023 Request held high SHALL start a new frame on the cycle after return to IDLE; request while busy SHALL be ignored, not queued.
REQ-024 Counters SHALL be sized with $clog2 of their terminal count plus one; no wrap before terminal count.

Reset
REQ-025 Reset SHALL force IDLE, vlx_clk_out=1, location_detection_value_out=0, position_valid_out=0, frame_error_out=0, busy_out=0, counters/shift register/synchronizer=0.
REQ-026 Reset mid-frame SHALL abort immediately (clock high next cycle), no valid pulse issued.

Configuration
REQ-027 Macro SSI_GRAY_DECODE_EN defined: the captured frame SHALL be Gray-to-binary converted (b[MSB]=g[MSB], b[i]=b[i+1]^g[i]) before loading location_detection_value_out, no added latency.
REQ-028 Macro SSI_GRAY_DECODE_EN undefined: raw captured frame SHALL be loaded, no conversion logic present.

Verification (DATA_BITS=13, CLK_DIV=8, MONOFLOP_CYCLES=40)
REQ-029 Encoder model sends 13'h0A5C, line high after monoflop, macro off -> value 13'h0A5C, valid pulse 146 cycles after request, error 0, 13 low clock pulses each 4 cycles.
REQ-030 Macro on, model sends Gray 13'h1000 -> value 13'h1FFF.
REQ-031 Data line held low at request -> no vlx_clk_out low, valid at +2 cycles, error 1, value unchanged.
REQ-032 Line low at end of monoflop -> error 1, value keeps previous 13'h0A5C.
REQ-033 Reset asserted during bit 6 -> vlx_clk_out high next cycle, all outputs 0, no valid pulse; next request gives correct frame.
REQ-034 Request held high continuously -> back-to-back frames, busy_out low exactly one cycle between frames, one valid pulse per frame.
